triangle_setup: RTL and testbench

//  Front-end setup stage feeding the rasterizer's triangle_valid/triangle_ready port.

---
 rtl/gpu_pkg.sv | 49 ++++
 rtl/recip_div.sv | 67 ++++++
 rtl/triangle_setup.sv | 183 ++++++++++++++++++
 tb/tb_triangle_setup.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared types and constants for the triangle setup front end.
package gpu_pkg;

    localparam int XW        = 9;              // vertex X width (0..511)
    localparam int YW        = 8;              // vertex Y width (0..255)
    localparam int ZW        = 16;             // per-vertex depth width
    localparam int INV_FRAC  = 24;             // fractional bits of inv_area
    localparam int DIV_STEPS = INV_FRAC + 2;   // quotient bits of floor(2^25/|2A|)
    localparam int DIV_W     = 17;             // |2A| <= 130305 fits in 17 bits
    localparam int REM_W     = DIV_W + 1;      // restoring-divide remainder width
    localparam int A2_W      = 20;             // signed 2*area width
    localparam int CNT_W     = $clog2(DIV_STEPS);

    // Dividend 2^25: one extra bit beyond INV_FRAC so the quotient can be rounded.
    localparam logic [DIV_STEPS-1:0] DIVIDEND = {1'b1, {(DIV_STEPS-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        AREA,
        DIV,
        OUT
    } setup_state_t;

    typedef struct packed {
        logic [XW-1:0] v1x;
        logic [XW-1:0] v2x;
        logic [XW-1:0] v3x;
        logic [YW-1:0] v1y;
        logic [YW-1:0] v2y;
        logic [YW-1:0] v3y;
        logic [7:0]    color;
        logic [ZW-1:0] z1;
        logic [ZW-1:0] z2;
        logic [ZW-1:0] z3;
    } tri_t;

    // Magnitude of the signed 2*area.
    function automatic logic [A2_W-1:0] abs_a2(input logic signed [A2_W-1:0] a);
        return a[A2_W-1] ? -a : a;
    endfunction

    // Round-half-up of q/2: turns floor(2^25/d) into round(2^24/d).
    function automatic logic [31:0] round_half(input logic [DIV_STEPS-1:0] q);
        logic [DIV_STEPS:0] q_plus;
        q_plus = {1'b0, q} + {{DIV_STEPS{1'b0}}, 1'b1};
        return 32'(q_plus >> 1);
    endfunction

endpackage

// File: rtl/recip_div.sv
// Restoring divider computing floor(2^25 / divisor), one quotient bit per cycle, MSB first.
// The start cycle produces the first bit, so done pulses after exactly DIV_STEPS cycles.
module recip_div
    import gpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DIV_W-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [DIV_STEPS-1:0] quotient
);

    logic [REM_W-1:0]     rem;
    logic [DIV_STEPS-1:0] dvd;
    logic [CNT_W-1:0]     cnt;

    logic [REM_W-1:0]     src_rem;
    logic [DIV_STEPS-1:0] src_dvd;
    logic [REM_W-1:0]     trial;
    logic                 q_bit;
    logic [REM_W-1:0]     next_rem;

    // One restoring step: shift the next dividend bit in, subtract when it fits.
    // NOTE: every variable gets a default at the top so no latch is inferred.
    always_comb begin
        src_rem  = start ? '0 : rem;
        src_dvd  = start ? DIVIDEND : dvd;
        trial    = {src_rem[REM_W-2:0], src_dvd[DIV_STEPS-1]};
        // A set top remainder bit means the shifted value already exceeds any divisor.
        q_bit    = src_rem[REM_W-1] | (trial >= {1'b0, divisor});
        next_rem = q_bit ? (trial - {1'b0, divisor}) : trial;
    end

    // Iteration registers: load-and-step on start, then one step per cycle until the count expires.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem      <= '0;
            dvd      <= '0;
            cnt      <= '0;
            quotient <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                rem      <= next_rem;
                dvd      <= {src_dvd[DIV_STEPS-2:0], 1'b0};
                quotient <= {{(DIV_STEPS-1){1'b0}}, q_bit};
                cnt      <= CNT_W'(DIV_STEPS - 1);
                busy     <= 1'b1;
            end else if (busy) begin
                rem      <= next_rem;
                dvd      <= {src_dvd[DIV_STEPS-2:0], 1'b0};
                quotient <= {quotient[DIV_STEPS-2:0], q_bit};
                cnt      <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/triangle_setup.sv
// Triangle setup: computes signed 2*area, culls degenerate triangles, and
// produces inv_area = round(2^24/|2A|) before handing the triangle to the rasterizer.
module triangle_setup
    import gpu_pkg::*;
(
    input  logic          axi_aclk,
    input  logic          axi_reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] in_v1x,
    input  logic [XW-1:0] in_v2x,
    input  logic [XW-1:0] in_v3x,
    input  logic [YW-1:0] in_v1y,
    input  logic [YW-1:0] in_v2y,
    input  logic [YW-1:0] in_v3y,
    input  logic [7:0]    in_color,
    input  logic [ZW-1:0] in_z1,
    input  logic [ZW-1:0] in_z2,
    input  logic [ZW-1:0] in_z3,
    output logic          triangle_valid,
    input  logic          triangle_ready,
    output logic [XW-1:0] v1x,
    output logic [XW-1:0] v2x,
    output logic [XW-1:0] v3x,
    output logic [YW-1:0] v1y,
    output logic [YW-1:0] v2y,
    output logic [YW-1:0] v3y,
    output logic [7:0]    color,
    output logic [ZW-1:0] z1,
    output logic [ZW-1:0] z2,
    output logic [ZW-1:0] z3,
    output logic [31:0]   inv_area,
    output logic          area_neg,
    output logic          cull_pulse,
    output logic [15:0]   cull_count
);

    setup_state_t state, state_nxt;

    tri_t                 tri_q;
    logic                 ready_en;       // low for the cycle after reset
    logic                 start_q;        // launches the divider on the first DIV cycle
    logic [DIV_W-1:0]     divisor_q;
    logic                 area_neg_q;
    logic [31:0]          inv_area_q;
    logic [15:0]          cull_count_q;
    logic                 accept;

    logic                 div_busy;
    logic                 div_done;
    logic [DIV_STEPS-1:0] div_quotient;

    logic signed [A2_W-1:0] x1_s, x2_s, x3_s;
    logic signed [A2_W-1:0] d23, d31, d12;
    logic signed [A2_W-1:0] a2;
    logic [A2_W-1:0]        a2_mag;
    logic                   zero_area;

    // Signed 2*area from the latched vertices; operands are widened so the wrapped sum is exact.
    always_comb begin
        x1_s      = A2_W'(tri_q.v1x);
        x2_s      = A2_W'(tri_q.v2x);
        x3_s      = A2_W'(tri_q.v3x);
        d23       = A2_W'(tri_q.v2y) - A2_W'(tri_q.v3y);
        d31       = A2_W'(tri_q.v3y) - A2_W'(tri_q.v1y);
        d12       = A2_W'(tri_q.v1y) - A2_W'(tri_q.v2y);
        a2        = x1_s * d23 + x2_s * d31 + x3_s * d12;
        a2_mag    = abs_a2(a2);
        zero_area = (a2_mag == '0);
    end

    // State register.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs; triangle_valid depends on state only.
    always_comb begin
        state_nxt      = state;
        in_ready       = 1'b0;
        triangle_valid = 1'b0;
        cull_pulse     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ready_en && !div_busy;
                if (in_valid && in_ready) begin
                    state_nxt = AREA;
                end
            end
            AREA: begin
                cull_pulse = zero_area;
                state_nxt  = zero_area ? IDLE : DIV;
            end
            DIV: begin
                if (div_done) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                triangle_valid = 1'b1;
                if (triangle_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // Datapath registers: triangle capture, area sign/magnitude, cull count and final reciprocal.
    // NOTE: the datapath registers are reset too because their reset values are visible on the outputs.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            tri_q        <= '0;
            ready_en     <= 1'b0;
            start_q      <= 1'b0;
            divisor_q    <= '0;
            area_neg_q   <= 1'b0;
            inv_area_q   <= '0;
            cull_count_q <= '0;
        end else begin
            ready_en <= 1'b1;
            start_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tri_q <= '{v1x: in_v1x, v2x: in_v2x, v3x: in_v3x,
                                   v1y: in_v1y, v2y: in_v2y, v3y: in_v3y,
                                   color: in_color,
                                   z1: in_z1, z2: in_z2, z3: in_z3};
                    end
                end
                AREA: begin
                    area_neg_q <= a2[A2_W-1];
                    divisor_q  <= a2_mag[DIV_W-1:0];
                    if (zero_area) begin
                        if (cull_count_q != '1) begin
                            cull_count_q <= cull_count_q + 16'd1;
                        end
                    end else begin
                        start_q <= 1'b1;
                    end
                end
                DIV: begin
                    if (div_done) begin
                        inv_area_q <= round_half(div_quotient);
                    end
                end
                default: ;
            endcase
        end
    end

    recip_div u_recip_div (
        .clk      (axi_aclk),
        .rst      (axi_reset),
        .start    (start_q),
        .divisor  (divisor_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    assign v1x        = tri_q.v1x;
    assign v2x        = tri_q.v2x;
    assign v3x        = tri_q.v3x;
    assign v1y        = tri_q.v1y;
    assign v2y        = tri_q.v2y;
    assign v3y        = tri_q.v3y;
    assign color      = tri_q.color;
    assign z1         = tri_q.z1;
    assign z2         = tri_q.z2;
    assign z3         = tri_q.z3;
    assign inv_area   = inv_area_q;
    assign area_neg   = area_neg_q;
    assign cull_count = cull_count_q;

endmodule

// File: tb/tb_triangle_setup.sv
// Self-checking bench for triangle_setup: directed vector table, randomized
// triangles against an arithmetic reference model, backpressure and mid-divide reset.
module tb_triangle_setup;

    logic        axi_aclk = 1'b0;
    logic        axi_reset;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_v1x, in_v2x, in_v3x;
    logic [7:0]  in_v1y, in_v2y, in_v3y;
    logic [7:0]  in_color;
    logic [15:0] in_z1, in_z2, in_z3;
    logic        triangle_valid;
    logic        triangle_ready;
    logic [8:0]  v1x, v2x, v3x;
    logic [7:0]  v1y, v2y, v3y;
    logic [7:0]  color;
    logic [15:0] z1, z2, z3;
    logic [31:0] inv_area;
    logic        area_neg;
    logic        cull_pulse;
    logic [15:0] cull_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cull_count = 0;

    typedef struct {
        logic [8:0]  x1, x2, x3;
        logic [7:0]  y1, y2, y3;
        logic [7:0]  col;
        logic [15:0] za, zb, zc;
        int          stall;
        bit          hold_valid;
        bit          exp_cull;
        bit          exp_neg;
        logic [31:0] exp_inv;
    } tvec_t;

    always #5 axi_aclk = ~axi_aclk;

    triangle_setup dut (
        .axi_aclk       (axi_aclk),
        .axi_reset      (axi_reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_v1x         (in_v1x),
        .in_v2x         (in_v2x),
        .in_v3x         (in_v3x),
        .in_v1y         (in_v1y),
        .in_v2y         (in_v2y),
        .in_v3y         (in_v3y),
        .in_color       (in_color),
        .in_z1          (in_z1),
        .in_z2          (in_z2),
        .in_z3          (in_z3),
        .triangle_valid (triangle_valid),
        .triangle_ready (triangle_ready),
        .v1x            (v1x),
        .v2x            (v2x),
        .v3x            (v3x),
        .v1y            (v1y),
        .v2y            (v2y),
        .v3y            (v3y),
        .color          (color),
        .z1             (z1),
        .z2             (z2),
        .z3             (z3),
        .inv_area       (inv_area),
        .area_neg       (area_neg),
        .cull_pulse     (cull_pulse),
        .cull_count     (cull_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic tvec_t mk(input int ax, input int ay, input int bx, input int by,
                                 input int cx, input int cy, input int col, input int z,
                                 input int stall, input bit hold, input bit cull,
                                 input bit neg, input logic [31:0] inv);
        tvec_t v;
        v.x1 = 9'(ax); v.y1 = 8'(ay);
        v.x2 = 9'(bx); v.y2 = 8'(by);
        v.x3 = 9'(cx); v.y3 = 8'(cy);
        v.col = 8'(col);
        v.za = 16'(z); v.zb = 16'(z); v.zc = 16'(z);
        v.stall = stall; v.hold_valid = hold;
        v.exp_cull = cull; v.exp_neg = neg; v.exp_inv = inv;
        return v;
    endfunction

    // Reference: cross product in plain integers, then round(2^24/|2A|) half-up.
    function automatic tvec_t model(input tvec_t v);
        longint a2, mag;
        tvec_t r;
        r  = v;
        a2 = longint'(v.x1) * (longint'(v.y2) - longint'(v.y3))
           + longint'(v.x2) * (longint'(v.y3) - longint'(v.y1))
           + longint'(v.x3) * (longint'(v.y1) - longint'(v.y2));
        mag = (a2 < 0) ? -a2 : a2;
        r.exp_cull = (a2 == 0);
        r.exp_neg  = (a2 < 0);
        r.exp_inv  = (mag == 0) ? 32'd0 : 32'((64'sd33554432 + mag) / (2 * mag));
        return r;
    endfunction

    task automatic drive_in(input tvec_t v);
        in_v1x = v.x1; in_v2x = v.x2; in_v3x = v.x3;
        in_v1y = v.y1; in_v2y = v.y2; in_v3y = v.y3;
        in_color = v.col;
        in_z1 = v.za; in_z2 = v.zb; in_z3 = v.zc;
    endtask

    task automatic check_outputs(input string tag, input tvec_t v);
        check({tag, "_inv_area"}, 64'(inv_area), 64'(v.exp_inv));
        check({tag, "_area_neg"}, 64'(area_neg), 64'(v.exp_neg));
        check({tag, "_verts"}, 64'({v1x, v1y, v2x, v2y, v3x, v3y}),
              64'({v.x1, v.y1, v.x2, v.y2, v.x3, v.y3}));
        check({tag, "_z_color"}, 64'({z1, z2, z3, color}), 64'({v.za, v.zb, v.zc, v.col}));
    endtask

    // Push one triangle and check culling or latency, results and the output handshake.
    task automatic run_tri(input string tag, input tvec_t v);
        int    waited;
        bit    early;
        tvec_t junk;
        waited = 0;
        while (!in_ready && waited < 64) begin
            @(posedge axi_aclk); #1;
            waited++;
        end
        check({tag, "_ready_wait"}, 64'(in_ready), 64'(1));
        if (!in_ready) return;
        drive_in(v);
        in_valid = 1'b1;
        triangle_ready = (v.stall == 0);
        @(posedge axi_aclk); #1;          // accept edge T
        in_valid = 1'b0;
        check({tag, "_busy_after_accept"}, 64'(in_ready), 64'(0));
        if (v.exp_cull) begin
            check({tag, "_cull_pulse"}, 64'(cull_pulse), 64'(1));
            check({tag, "_cull_no_valid"}, 64'(triangle_valid), 64'(0));
            @(posedge axi_aclk); #1;      // T+1
            exp_cull_count = (exp_cull_count < 65535) ? exp_cull_count + 1 : 65535;
            check({tag, "_cull_pulse_end"}, 64'(cull_pulse), 64'(0));
            check({tag, "_cull_count"}, 64'(cull_count), 64'(exp_cull_count));
            check({tag, "_cull_ready_back"}, 64'(in_ready), 64'(1));
            check({tag, "_cull_still_no_valid"}, 64'(triangle_valid), 64'(0));
            triangle_ready = 1'b0;
            return;
        end
        early = 1'b0;
        repeat (27) begin
            @(posedge axi_aclk); #1;
            if (triangle_valid) early = 1'b1;
        end
        check({tag, "_valid_not_before_T28"}, 64'(early), 64'(0));
        @(posedge axi_aclk); #1;          // T+28
        check({tag, "_valid_at_T28"}, 64'(triangle_valid), 64'(1));
        check_outputs(tag, v);
        if (v.hold_valid) begin
            junk = v;
            junk.x1 = ~v.x1; junk.x2 = ~v.x2; junk.x3 = ~v.x3;
            junk.y1 = ~v.y1; junk.y2 = ~v.y2; junk.y3 = ~v.y3;
            junk.col = ~v.col; junk.za = ~v.za;
            drive_in(junk);
            in_valid = 1'b1;
        end
        for (int s = 0; s < v.stall; s++) begin
            @(posedge axi_aclk); #1;
            check({tag, "_hold_valid"}, 64'(triangle_valid), 64'(1));
            check({tag, "_hold_inv"}, 64'(inv_area), 64'(v.exp_inv));
            check({tag, "_hold_verts"}, 64'({v1x, v1y, v2x, v2y, v3x, v3y, color}),
                  64'({v.x1, v.y1, v.x2, v.y2, v.x3, v.y3, v.col}));
            check({tag, "_hold_not_ready"}, 64'(in_ready), 64'(0));
        end
        triangle_ready = 1'b1;
        @(posedge axi_aclk); #1;          // handshake edge
        triangle_ready = 1'b0;
        in_valid = 1'b0;
        check({tag, "_valid_drop"}, 64'(triangle_valid), 64'(0));
        check({tag, "_ready_after_out"}, 64'(in_ready), 64'(1));
        if (v.hold_valid) begin
            check({tag, "_held_input_ignored"}, 64'({v1x, v1y, color}), 64'({v.x1, v.y1, v.col}));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tvec_t vecs [7];
        tvec_t t0;
        tvec_t r;
        bit    saw_valid;

        vecs[0] = mk(40, 20, 140, 120, 40, 120, 'hE0, 50, 0, 0, 0, 0, 32'h0000068E);
        vecs[1] = mk(140, 20, 90, 70, 190, 70, 'h1C, 7, 1, 0, 0, 1, 32'h00000D1B);
        vecs[2] = mk(0, 0, 1, 0, 0, 1, 'hFF, 1, 0, 0, 0, 0, 32'h01000000);
        vecs[3] = mk(0, 0, 511, 0, 0, 255, 'h03, 65535, 2, 0, 0, 0, 32'h00000081);
        vecs[4] = mk(10, 10, 20, 20, 30, 30, 'h55, 9, 0, 0, 1, 0, 32'h00000000);
        vecs[5] = mk(20, 140, 70, 200, 20, 200, 'hA5, 300, 50, 1, 0, 0, 32'h000015D8);
        vecs[6] = mk(0, 0, 0, 1, 1, 0, 'h12, 4, 0, 0, 0, 1, 32'h01000000);

        axi_reset = 1'b1;
        in_valid = 1'b0;
        triangle_ready = 1'b0;
        t0 = vecs[0];
        t0.x1 = '0; t0.x2 = '0; t0.x3 = '0; t0.y1 = '0; t0.y2 = '0; t0.y3 = '0;
        t0.col = '0; t0.za = '0; t0.zb = '0; t0.zc = '0;
        drive_in(t0);

        // Reset values, then in_ready rises one cycle after reset is released.
        @(posedge axi_aclk); #1;
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_valid", 64'(triangle_valid), 64'(0));
        check("rst_cull", 64'({cull_pulse, cull_count}), 64'(0));
        check("rst_inv_neg", 64'({inv_area, area_neg}), 64'(0));
        check("rst_outputs", 64'({v1x, v1y, v2x, v2y, v3x, v3y, color}), 64'(0));
        check("rst_z", 64'({z1, z2, z3}), 64'(0));
        axi_reset = 1'b0;
        @(posedge axi_aclk); #1;
        check("rst_ready_after", 64'(in_ready), 64'(1));

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            run_tri($sformatf("vec%0d", i), vecs[i]);
        end

        // Random triangles against the reference model; every fourth is degenerate.
        for (int i = 0; i < 20; i++) begin
            r = vecs[0];
            r.x1 = 9'($urandom_range(0, 511)); r.y1 = 8'($urandom_range(0, 255));
            r.x2 = 9'($urandom_range(0, 511)); r.y2 = 8'($urandom_range(0, 255));
            r.x3 = 9'($urandom_range(0, 511)); r.y3 = 8'($urandom_range(0, 255));
            if (i % 4 == 3) begin
                r.x3 = r.x1; r.y3 = r.y1;
            end
            r.col = 8'($urandom); r.za = 16'($urandom); r.zb = 16'($urandom); r.zc = 16'($urandom);
            r.stall = $urandom_range(0, 3);
            r.hold_valid = 1'b0;
            r = model(r);
            run_tri($sformatf("rnd%0d", i), r);
        end

        // Reset in the middle of the divide discards the triangle.
        drive_in(vecs[1]);
        in_valid = 1'b1;
        @(posedge axi_aclk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge axi_aclk);
        #1;
        axi_reset = 1'b1;
        @(posedge axi_aclk); #1;
        axi_reset = 1'b0;
        exp_cull_count = 0;
        check("mid_rst_valid", 64'(triangle_valid), 64'(0));
        check("mid_rst_in_ready", 64'(in_ready), 64'(0));
        check("mid_rst_inv_area", 64'(inv_area), 64'(0));
        check("mid_rst_cull_count", 64'(cull_count), 64'(0));
        check("mid_rst_verts", 64'({v1x, v1y, v2x, v2y, v3x, v3y}), 64'(0));
        @(posedge axi_aclk); #1;
        check("mid_rst_ready_back", 64'(in_ready), 64'(1));
        saw_valid = 1'b0;
        repeat (30) begin
            @(posedge axi_aclk); #1;
            if (triangle_valid) saw_valid = 1'b1;
        end
        check("mid_rst_no_valid", 64'(saw_valid), 64'(0));
        run_tri("post_rst", vecs[0]);
        run_tri("post_rst_cull", vecs[4]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
